seven_segment_editor: RTL and testbench

SEVEN_SEGMENT_EDITOR -- requirements
Module: seven_segment_editor

---
 rtl/seven_segment_pkg.sv | 31 +++
 rtl/seven_segment_decoder.sv | 16 +
 rtl/seven_segment_editor.sv | 217 +++++++++++++++++++++
 tb/tb_seven_segment_editor.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment editor: the active-low hex glyph
// table, the decimal-point bit position and the all-off blank pattern.
package seven_segment_pkg;

  // Bit position of the decimal point inside the 8-bit segment word.
  localparam int SEG_DP_BIT = 7;

  // Segment word that turns every segment (including dp) off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low glyphs, bits [6:0] = g,f,e,d,c,b,a; index = hex nibble.
  localparam logic [6:0] SEG_HEX_TABLE [16] = '{
    7'h40,  // 0
    7'h79,  // 1
    7'h24,  // 2
    7'h30,  // 3
    7'h19,  // 4
    7'h12,  // 5
    7'h02,  // 6
    7'h78,  // 7
    7'h00,  // 8
    7'h10,  // 9
    7'h08,  // A
    7'h03,  // b
    7'h46,  // C
    7'h21,  // d
    7'h06,  // E
    7'h0E   // F
  };

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational hex nibble + decimal point to active-low segment word.
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       point_i,
  output logic [7:0] segment_n_o
);

  // Look up the glyph and attach the active-low decimal point.
  always_comb begin
    segment_n_o             = {1'b1, SEG_HEX_TABLE[nibble_i]};
    segment_n_o[SEG_DP_BIT] = ~point_i;
  end

endmodule

// File: rtl/seven_segment_editor.sv
// Multiplexed hex display with an editable value, per-digit decimal points
// and a movable cursor. Digits are scanned one slot of 2**CLOCK_DIVISIONS
// cycles at a time; segment and digit drives are registered.
// Optional feature: define SEVEN_SEGMENT_BLINK_EN to blank the cursor digit
// during alternate 2**BLINK_DIVISIONS-cycle half-periods.
module seven_segment_editor
  import seven_segment_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int CLOCK_DIVISIONS = 18,
  parameter int BLINK_DIVISIONS = 24
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       loadPulse,
  input  logic [4*DIGITS-1:0]        loadData,
  input  logic                       leftPulse,
  input  logic                       rightPulse,
  input  logic                       upPulse,
  input  logic                       downPulse,
  input  logic                       togglePulse,
  output logic [4*DIGITS-1:0]        value,
  output logic [DIGITS-1:0]          pointEnable,
  output logic [$clog2(DIGITS)-1:0]  cursor,
  output logic [7:0]                 segmentEnableN,
  output logic [DIGITS-1:0]          digitEnableN
);

  localparam int CW = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  // Parameter sanity checks at elaboration.
  if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
    $error("seven_segment_editor: DIGITS must be within 2..8");
  end
  if (CLOCK_DIVISIONS < 1) begin : g_bad_clock_div
    $error("seven_segment_editor: CLOCK_DIVISIONS must be at least 1");
  end
  if (BLINK_DIVISIONS <= CLOCK_DIVISIONS) begin : g_bad_blink_div
    $error("seven_segment_editor: BLINK_DIVISIONS must exceed CLOCK_DIVISIONS");
  end

  logic [4*DIGITS-1:0]        value_q, value_d;
  logic [DIGITS-1:0]          point_q, point_d;
  logic [CW-1:0]              cursor_q, cursor_d;
  logic [CLOCK_DIVISIONS-1:0] scan_cnt_q, scan_cnt_d;
  logic [CW-1:0]              scan_idx_q, scan_idx_d;
  logic [7:0]                 seg_q, seg_d;
  logic [DIGITS-1:0]          dig_q, dig_d;

  logic [3:0] disp_nibble_s;
  logic       disp_point_s;
  logic [7:0] decoded_s;
  logic       blank_s;

  // Cursor movement; opposite strobes together cancel, both ends wrap.
  always_comb begin
    cursor_d = cursor_q;
    if (leftPulse && !rightPulse) begin
      if (cursor_q == LAST_DIGIT) begin
        cursor_d = '0;
      end else begin
        cursor_d = cursor_q + CW'(1);
      end
    end else if (rightPulse && !leftPulse) begin
      if (cursor_q == '0) begin
        cursor_d = LAST_DIGIT;
      end else begin
        cursor_d = cursor_q - CW'(1);
      end
    end else begin
      cursor_d = cursor_q;
    end
  end

  // Value and point edits at the pre-move cursor; load beats up/down.
  always_comb begin
    value_d = value_q;
    point_d = point_q;
    if (loadPulse) begin
      value_d = loadData;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (CW'(i) == cursor_q) begin
          if (upPulse && !downPulse) begin
            value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
          end else if (downPulse && !upPulse) begin
            value_d[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
          end else begin
            value_d[4*i +: 4] = value_q[4*i +: 4];
          end
        end else begin
          value_d[4*i +: 4] = value_q[4*i +: 4];
        end
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (togglePulse && (CW'(i) == cursor_q)) begin
        point_d[i] = ~point_q[i];
      end else begin
        point_d[i] = point_q[i];
      end
    end
  end

  // Free-running slot counter; the scanned digit advances when it wraps.
  always_comb begin
    scan_cnt_d = scan_cnt_q + CLOCK_DIVISIONS'(1);
    scan_idx_d = scan_idx_q;
    if (&scan_cnt_q) begin
      if (scan_idx_q == LAST_DIGIT) begin
        scan_idx_d = '0;
      end else begin
        scan_idx_d = scan_idx_q + CW'(1);
      end
    end else begin
      scan_idx_d = scan_idx_q;
    end
  end

  // Pick the nibble and point of the digit currently being scanned.
  always_comb begin
    disp_nibble_s = 4'h0;
    disp_point_s  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (CW'(i) == scan_idx_q) begin
        disp_nibble_s = value_q[4*i +: 4];
        disp_point_s  = point_q[i];
      end else begin
        disp_nibble_s = disp_nibble_s;
        disp_point_s  = disp_point_s;
      end
    end
  end

  seven_segment_decoder u_decoder (
    .nibble_i    (disp_nibble_s),
    .point_i     (disp_point_s),
    .segment_n_o (decoded_s)
  );

`ifdef SEVEN_SEGMENT_BLINK_EN
  // One extra bit so the MSB half-period is 2**BLINK_DIVISIONS cycles.
  localparam int BLINK_BITS = BLINK_DIVISIONS + 1;

  logic [BLINK_BITS-1:0] blink_q, blink_d;

  // Blink phase counter free-runs alongside the scan counter.
  always_comb begin
    blink_d = blink_q + BLINK_BITS'(1);
  end

  // Blink phase register.
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end

  // Blank only the cursor digit, and only in the upper blink half-period.
  always_comb begin
    blank_s = blink_q[BLINK_BITS-1] && (scan_idx_q == cursor_q);
  end
`else
  // Without blinking the cursor digit displays like any other.
  always_comb begin
    blank_s = 1'b0;
  end
`endif

  // Next segment/digit drive for the scanned digit.
  always_comb begin
    if (blank_s) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = decoded_s;
    end
    dig_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (CW'(i) == scan_idx_q) begin
        dig_d[i] = 1'b0;
      end else begin
        dig_d[i] = 1'b1;
      end
    end
  end

  // Editor state, scan state and registered display drives.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q    <= '0;
      point_q    <= '0;
      cursor_q   <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= SEG_BLANK;
      dig_q      <= '1;
    end else begin
      value_q    <= value_d;
      point_q    <= point_d;
      cursor_q   <= cursor_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign value          = value_q;
  assign pointEnable    = point_q;
  assign cursor         = cursor_q;
  assign segmentEnableN = seg_q;
  assign digitEnableN   = dig_q;

endmodule

// File: tb/tb_seven_segment_editor.sv
// Directed bench for seven_segment_editor: a 4-digit instance for editing,
// display and blink behaviour and a 3-digit instance for non-power-of-two
// scanning and mid-slot reset.
module tb_seven_segment_editor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-digit instance signals.
  logic        rst, load, left, right, up, down, toggle;
  logic [15:0] ldata;
  logic [15:0] value4;
  logic [3:0]  point4;
  logic [1:0]  cursor4;
  logic [7:0]  seg4;
  logic [3:0]  dig4;

  // 3-digit instance signals.
  logic        rst3;
  logic        zero3 = 1'b0;
  logic [11:0] ldata3 = 12'h000;
  logic [11:0] value3;
  logic [2:0]  point3;
  logic [1:0]  cursor3;
  logic [7:0]  seg3;
  logic [2:0]  dig3;

  int checks = 0;
  int fails  = 0;

  logic       blink_on;
  logic [3:0] exp_dig4;
  logic [2:0] exp_dig3;
  logic [7:0] exp_seg;
  int         idx;
  bit         found;

  seven_segment_editor #(.DIGITS(4), .CLOCK_DIVISIONS(2), .BLINK_DIVISIONS(4)) dut4 (
    .clock(clk), .reset(rst), .loadPulse(load), .loadData(ldata),
    .leftPulse(left), .rightPulse(right), .upPulse(up), .downPulse(down),
    .togglePulse(toggle), .value(value4), .pointEnable(point4),
    .cursor(cursor4), .segmentEnableN(seg4), .digitEnableN(dig4)
  );

  seven_segment_editor #(.DIGITS(3), .CLOCK_DIVISIONS(2), .BLINK_DIVISIONS(4)) dut3 (
    .clock(clk), .reset(rst3), .loadPulse(zero3), .loadData(ldata3),
    .leftPulse(zero3), .rightPulse(zero3), .upPulse(zero3), .downPulse(zero3),
    .togglePulse(zero3), .value(value3), .pointEnable(point3),
    .cursor(cursor3), .segmentEnableN(seg3), .digitEnableN(dig3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle away from the edge and drop all strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    load = 1'b0; left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0; toggle = 1'b0;
  endtask

  initial begin
`ifdef SEVEN_SEGMENT_BLINK_EN
    blink_on = 1'b1;
`else
    blink_on = 1'b0;
`endif
    rst = 1'b1; rst3 = 1'b1; ldata = 16'h0000;
    load = 1'b0; left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0; toggle = 1'b0;
    tick(); tick();

    // Reset state.
    check("rst_value",  value4,  16'h0000);
    check("rst_point",  point4,  4'b0000);
    check("rst_cursor", cursor4, 2'd0);
    check("rst_seg",    seg4,    8'hFF);
    check("rst_dig",    dig4,    4'b1111);

    // Load and first digit-0 slot.
    rst = 1'b0;
    load = 1'b1; ldata = 16'h12AF; tick();
    check("load_value", value4, 16'h12AF);
    tick();
    check("slot0_seg", seg4, 8'h8E);
    check("slot0_dig", dig4, 4'b1110);

    // Cursor movement and wrap.
    left = 1'b1; tick(); check("left1", cursor4, 2'd1);
    left = 1'b1; tick(); check("left2", cursor4, 2'd2);
    left = 1'b1; tick(); check("left3", cursor4, 2'd3);
    left = 1'b1; tick(); check("left_wrap", cursor4, 2'd0);
    right = 1'b1; tick(); check("right_wrap", cursor4, 2'd3);
    left = 1'b1; right = 1'b1; tick(); check("left_right", cursor4, 2'd3);
    left = 1'b1; tick(); check("back_to0", cursor4, 2'd0);
    left = 1'b1; tick(); left = 1'b1; tick(); check("cursor2", cursor4, 2'd2);

    // Nibble edits at cursor 2.
    load = 1'b1; ldata = 16'h0F00; tick(); check("load_0f00", value4, 16'h0F00);
    up = 1'b1; tick(); check("up_wrap", value4, 16'h0000);
    down = 1'b1; tick(); check("down_wrap", value4, 16'h0F00);
    up = 1'b1; down = 1'b1; tick(); check("up_down", value4, 16'h0F00);
    load = 1'b1; up = 1'b1; ldata = 16'h5A3C; tick(); check("load_prio", value4, 16'h5A3C);
    up = 1'b1; left = 1'b1; tick();
    check("edit_premove_val", value4, 16'h5B3C);
    check("edit_premove_cur", cursor4, 2'd3);
    right = 1'b1; tick(); right = 1'b1; tick(); check("cursor1", cursor4, 2'd1);

    // Decimal point toggles at cursor 1.
    toggle = 1'b1; tick(); check("toggle_on", point4, 4'b0010);
    toggle = 1'b1; up = 1'b1; tick();
    check("toggle_off", point4, 4'b0000);
    check("toggle_up_val", value4, 16'h5B4C);
    toggle = 1'b1; tick(); check("toggle_on2", point4, 4'b0010);
    right = 1'b1; tick(); check("cursor0", cursor4, 2'd0);

    // Digit 1 slot shows '4' with its decimal point lit.
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      tick();
      if (dig4 == 4'b1101) found = 1'b1;
    end
    check("slot1_found", {31'd0, found}, 32'd1);
    check("slot1_dp", {31'd0, seg4[7]}, 32'd0);
    check("slot1_seg", seg4, 8'h19);

    // Reset overrides strobes asserted in the same cycle.
    rst = 1'b1; load = 1'b1; ldata = 16'hFFFF; left = 1'b1; toggle = 1'b1; up = 1'b1;
    tick();
    check("rst2_value",  value4,  16'h0000);
    check("rst2_point",  point4,  4'b0000);
    check("rst2_cursor", cursor4, 2'd0);
    check("rst2_seg",    seg4,    8'hFF);
    check("rst2_dig",    dig4,    4'b1111);
    rst = 1'b0;

    // Scan sequence from reset, value 0, cursor 0 (blink on digit 0 only).
    for (int k = 1; k <= 64; k++) begin
      tick();
      idx = ((k - 1) >> 2) & 3;
      exp_dig4 = ~(4'b0001 << idx);
      if (blink_on && idx == 0 && (((k - 1) >> 4) & 1) == 1) exp_seg = 8'hFF;
      else exp_seg = 8'hC0;
      check("scan4_dig", dig4, exp_dig4);
      check("scan4_seg", seg4, exp_seg);
    end

    // 3-digit scan: 110,101,011,110 each for 4 cycles.
    rst3 = 1'b1; tick(); rst3 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      idx = ((k - 1) >> 2) % 3;
      exp_dig3 = ~(3'b001 << idx);
      check("scan3_dig", dig3, exp_dig3);
    end
    // Advance into slot 2, then reset mid-slot.
    rst3 = 1'b1; tick(); rst3 = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    check("mid_slot2", dig3, 3'b011);
    rst3 = 1'b1; tick();
    check("rst3_dig", dig3, 3'b111);
    check("rst3_seg", seg3, 8'hFF);
    rst3 = 1'b0; tick();
    check("restart_dig0", dig3, 3'b110);
    check("restart_seg",  seg3, 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
